// File: rtl/pipe_ereg_ctl.sv
// Decode-to-execute pipeline register plus hazard control for the Y86 pipeline.
// Latency: D->E is one cycle; control outputs are combinational in the same cycle.
// Backpressure: F/D are held via F_stall/D_stall; E is never stalled, only bubbled.
//
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   D_*, d_*                decode-stage fields loaded into E at each edge
//   e_Cnd                   branch condition from execute (for mispredict)
//   M_icode                 memory-stage icode (for ret detection)
//   E_*                     current contents of the E pipeline register
//   F_stall, D_stall        hold the fetch / decode registers
//   D_bubble, E_bubble      replace the next D / E contents with a nop
//   bubble_cnt, stall_cnt   saturating perf counters of E_bubble / D_stall cycles
module pipe_ereg_ctl #(
  parameter int          CNT_W = 32,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_stat,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       D_ifun,
  input  logic [63:0]      D_valC,
  input  logic [63:0]      d_valA,
  input  logic [63:0]      d_valB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  output logic [3:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [63:0]      E_valC,
  output logic [63:0]      E_valA,
  output logic [63:0]      E_valB,
  output logic [3:0]       E_dstE,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] S_AOK    = 4'h1;

  // E register state
  logic [3:0]  stat_q,  stat_d;
  logic [3:0]  icode_q, icode_d;
  logic [3:0]  ifun_q,  ifun_d;
  logic [63:0] valc_q,  valc_d;
  logic [63:0] vala_q,  vala_d;
  logic [63:0] valb_q,  valb_d;
  logic [3:0]  dste_q,  dste_d;
  logic [3:0]  dstm_q,  dstm_d;
  logic [3:0]  srca_q,  srca_d;
  logic [3:0]  srcb_q,  srcb_d;

  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic load_use;
  logic mispredict;
  logic ret_pend;

  // Hazard detection works on the current E contents, so a freshly inserted
  // bubble (icode NOP, dstM RNONE) can never re-trigger a hazard by itself.
  always_comb begin
    load_use   = ((icode_q == I_MRMOVQ) || (icode_q == I_POPQ)) &&
                 (dstm_q != RNONE) &&
                 ((dstm_q == d_srcA) || (dstm_q == d_srcB));
    mispredict = (icode_q == I_JXX) && !e_Cnd;
    ret_pend   = (D_icode == I_RET) || (icode_q == I_RET) || (M_icode == I_RET);
  end

  // load_use and mispredict are exclusive (different E_icode), so no priority
  // is needed. A load/use stall wins over the ret bubble in D: the ret must
  // stay in D until its operand is available.
  always_comb begin
    F_stall  = load_use | ret_pend;
    D_stall  = load_use;
    D_bubble = mispredict | (ret_pend & ~load_use);
    E_bubble = mispredict | load_use;
  end

  // Next E contents: bubble or decode-stage values. Reset is handled in the
  // sequential block so it overrides everything, including pending hazards.
  always_comb begin
    if (E_bubble) begin
      stat_d  = S_AOK;
      icode_d = I_NOP;
      ifun_d  = 4'h0;
      valc_d  = 64'h0;
      vala_d  = 64'h0;
      valb_d  = 64'h0;
      dste_d  = RNONE;
      dstm_d  = RNONE;
      srca_d  = RNONE;
      srcb_d  = RNONE;
    end else begin
      stat_d  = D_stat;
      icode_d = D_icode;
      ifun_d  = D_ifun;
      valc_d  = D_valC;
      vala_d  = d_valA;
      valb_d  = d_valB;
      dste_d  = d_dstE;
      dstm_d  = d_dstM;
      srca_d  = d_srcA;
      srcb_d  = d_srcB;
    end
  end

  // Saturating counters: hold at all-ones instead of wrapping so a long run
  // still reads as "at least this many".
  always_comb begin
    bcnt_d = bcnt_q;
    scnt_d = scnt_q;
    if (E_bubble && (bcnt_q != {CNT_W{1'b1}})) begin
      bcnt_d = bcnt_q + 1'b1;
    end
    if (D_stall && (scnt_q != {CNT_W{1'b1}})) begin
      scnt_d = scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_q  <= S_AOK;
      icode_q <= I_NOP;
      ifun_q  <= 4'h0;
      valc_q  <= 64'h0;
      vala_q  <= 64'h0;
      valb_q  <= 64'h0;
      dste_q  <= RNONE;
      dstm_q  <= RNONE;
      srca_q  <= RNONE;
      srcb_q  <= RNONE;
      bcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      valc_q  <= valc_d;
      vala_q  <= vala_d;
      valb_q  <= valb_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign E_stat     = stat_q;
  assign E_icode    = icode_q;
  assign E_ifun     = ifun_q;
  assign E_valC     = valc_q;
  assign E_valA     = vala_q;
  assign E_valB     = valb_q;
  assign E_dstE     = dste_q;
  assign E_dstM     = dstm_q;
  assign E_srcA     = srca_q;
  assign E_srcB     = srcb_q;
  assign bubble_cnt = bcnt_q;
  assign stall_cnt  = scnt_q;

endmodule

// File: tb/tb_pipe_ereg_ctl.sv
// Directed bench for pipe_ereg_ctl with a queue-based scoreboard.
// Each vector drives D-stage inputs and pushes the hand-computed state expected
// in that same cycle; the monitor pops and compares on the falling edge.
module tb_pipe_ereg_ctl;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       D_stat, D_icode, D_ifun;
  logic [63:0]      D_valC, d_valA, d_valB;
  logic [3:0]       d_dstE, d_dstM, d_srcA, d_srcB;
  logic             e_Cnd;
  logic [3:0]       M_icode;
  logic [3:0]       E_stat, E_icode, E_ifun;
  logic [63:0]      E_valC, E_valA, E_valB;
  logic [3:0]       E_dstE, E_dstM, E_srcA, E_srcB;
  logic             F_stall, D_stall, D_bubble, E_bubble;
  logic [CNT_W-1:0] bubble_cnt, stall_cnt;

  pipe_ereg_ctl #(.CNT_W(CNT_W), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_valC(D_valC),
    .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ctl;    // {F_stall, D_stall, D_bubble, E_bubble}
    logic [3:0]  stat, icode, ifun;
    logic [63:0] valc, vala, valb;
    logic [3:0]  dste, dstm, srca, srcb;
    int          bcnt, scnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: the expected record for a cycle is pushed after the rising edge
  // and consumed at the falling edge of the same cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] act_ctl;
      e = exp_q.pop_front();
      act_ctl = {F_stall, D_stall, D_bubble, E_bubble};
      n_tests++;
      if (act_ctl !== e.ctl || E_stat !== e.stat || E_icode !== e.icode ||
          E_ifun !== e.ifun || E_valC !== e.valc || E_valA !== e.vala ||
          E_valB !== e.valb || E_dstE !== e.dste || E_dstM !== e.dstm ||
          E_srcA !== e.srca || E_srcB !== e.srcb ||
          int'(bubble_cnt) != e.bcnt || int'(stall_cnt) != e.scnt) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b stat=%h ic=%h fn=%h C=%h A=%h B=%h dE=%h dM=%h sA=%h sB=%h bc=%0d sc=%0d",
                 e.name, act_ctl, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
                 E_dstE, E_dstM, E_srcA, E_srcB, bubble_cnt, stall_cnt);
        $display("     %s: want ctl=%b stat=%h ic=%h fn=%h C=%h A=%h B=%h dE=%h dM=%h sA=%h sB=%h bc=%0d sc=%0d",
                 e.name, e.ctl, e.stat, e.icode, e.ifun, e.valc, e.vala, e.valb,
                 e.dste, e.dstm, e.srca, e.srcb, e.bcnt, e.scnt);
      end
    end
  end

  task automatic drive(input bit rst, input logic [3:0] st, ic, dm, sa, sb,
                       input logic [63:0] va, input bit cnd, input logic [3:0] mi);
    rst_n   = rst;
    D_stat  = st;
    D_icode = ic;
    D_ifun  = 4'h3;
    D_valC  = 64'hC0;
    d_valA  = va;
    d_valB  = 64'hB0;
    d_dstE  = 4'h1;
    d_dstM  = dm;
    d_srcA  = sa;
    d_srcB  = sb;
    e_Cnd   = cnd;
    M_icode = mi;
  endtask

  // One cycle: drive inputs, push the expected state for this cycle, step.
  // xbub=1 means E should hold the bubble value (the x* E fields are ignored).
  task automatic vec(input string nm, input bit rst, input logic [3:0] st, ic, dm, sa, sb,
                     input logic [63:0] va, input bit cnd, input logic [3:0] mi,
                     input logic [3:0] xctl, input bit xbub, input logic [3:0] xst, xic,
                     input logic [63:0] xva, input logic [3:0] xdm, xsa, xsb,
                     input int xb, input int xs);
    exp_t e;
    drive(rst, st, ic, dm, sa, sb, va, cnd, mi);
    e.name = nm;
    e.ctl  = xctl;
    e.bcnt = xb;
    e.scnt = xs;
    if (xbub) begin
      e.stat = 4'h1; e.icode = 4'h1; e.ifun = 4'h0;
      e.valc = 64'h0; e.vala = 64'h0; e.valb = 64'h0;
      e.dste = 4'hF; e.dstm = 4'hF; e.srca = 4'hF; e.srcb = 4'hF;
    end else begin
      e.stat = xst; e.icode = xic; e.ifun = 4'h3;
      e.valc = 64'hC0; e.vala = xva; e.valb = 64'hB0;
      e.dste = 4'h1; e.dstm = xdm; e.srca = xsa; e.srcb = xsb;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b;
    drive(1'b0, 4'h1, 4'h6, 4'hF, 4'h2, 4'h3, 64'h11, 1'b1, 4'h0);
    @(posedge clk);
    #1;
    //        name          rst st    ic    dM    sA    sB    valA    cnd Mi      ctl     bub xst   xic   xvalA   xdM   xsA   xsB  bc sc
    vec("reset1",        0, 4'h1, 4'h6, 4'hF, 4'h2, 4'h3, 64'h11, 1, 4'h0,  4'b0000, 1, 4'h0, 4'h0, 64'h0,  4'h0, 4'h0, 4'h0, 0, 0);
    vec("reset2",        1, 4'h1, 4'h6, 4'hF, 4'h2, 4'h3, 64'h11, 1, 4'h0,  4'b0000, 1, 4'h0, 4'h0, 64'h0,  4'h0, 4'h0, 4'h0, 0, 0);
    vec("release_load",  1, 4'h1, 4'h5, 4'h3, 4'hF, 4'h4, 64'h22, 1, 4'h0,  4'b0000, 0, 4'h1, 4'h6, 64'h11, 4'hF, 4'h2, 4'h3, 0, 0);
    vec("lu_srcB_hit",   1, 4'h1, 4'h6, 4'hF, 4'h1, 4'h3, 64'h33, 1, 4'h0,  4'b1101, 0, 4'h1, 4'h5, 64'h22, 4'h3, 4'hF, 4'h4, 0, 0);
    vec("lu_bubbled",    1, 4'h1, 4'h6, 4'hF, 4'h1, 4'h3, 64'h33, 1, 4'h0,  4'b0000, 1, 4'h0, 4'h0, 64'h0,  4'h0, 4'h0, 4'h0, 1, 1);
    vec("lu_replay",     1, 4'h1, 4'h5, 4'h3, 4'hF, 4'h4, 64'h44, 1, 4'h0,  4'b0000, 0, 4'h1, 4'h6, 64'h33, 4'hF, 4'h1, 4'h3, 1, 1);
    vec("lu_miss",       1, 4'h1, 4'h6, 4'hF, 4'h2, 4'h2, 64'h55, 1, 4'h0,  4'b0000, 0, 4'h1, 4'h5, 64'h44, 4'h3, 4'hF, 4'h4, 1, 1);
    vec("lu_miss_load",  1, 4'h1, 4'hB, 4'h5, 4'h4, 4'h4, 64'h66, 1, 4'h0,  4'b0000, 0, 4'h1, 4'h6, 64'h55, 4'hF, 4'h2, 4'h2, 1, 1);
    vec("lu_popq_srcA",  1, 4'h1, 4'h6, 4'hF, 4'h5, 4'h1, 64'h77, 1, 4'h0,  4'b1101, 0, 4'h1, 4'hB, 64'h66, 4'h5, 4'h4, 4'h4, 1, 1);
    vec("popq_bubbled",  1, 4'h1, 4'h7, 4'hF, 4'hF, 4'hF, 64'h88, 1, 4'h0,  4'b0000, 1, 4'h0, 4'h0, 64'h0,  4'h0, 4'h0, 4'h0, 2, 2);
    vec("mispredict",    1, 4'h1, 4'h6, 4'hF, 4'h1, 4'h2, 64'h99, 0, 4'h0,  4'b0011, 0, 4'h1, 4'h7, 64'h88, 4'hF, 4'hF, 4'hF, 2, 2);
    vec("mp_bubbled",    1, 4'h1, 4'h7, 4'hF, 4'hF, 4'hF, 64'hAA, 0, 4'h0,  4'b0000, 1, 4'h0, 4'h0, 64'h0,  4'h0, 4'h0, 4'h0, 3, 2);
    vec("jxx_taken",     1, 4'h1, 4'h6, 4'hF, 4'h1, 4'h2, 64'hBB, 1, 4'h0,  4'b0000, 0, 4'h1, 4'h7, 64'hAA, 4'hF, 4'hF, 4'hF, 3, 2);
    vec("ret_in_D",      1, 4'h1, 4'h9, 4'hF, 4'h4, 4'h4, 64'hCC, 1, 4'h0,  4'b1010, 0, 4'h1, 4'h6, 64'hBB, 4'hF, 4'h1, 4'h2, 3, 2);
    vec("ret_in_E",      1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 64'h0,  1, 4'h0,  4'b1010, 0, 4'h1, 4'h9, 64'hCC, 4'hF, 4'h4, 4'h4, 3, 2);
    vec("ret_in_M",      1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 64'h0,  1, 4'h9,  4'b1010, 0, 4'h1, 4'h1, 64'h0,  4'hF, 4'hF, 4'hF, 3, 2);
    vec("ret_gone",      1, 4'h1, 4'h5, 4'h3, 4'hF, 4'h4, 64'hDD, 1, 4'h0,  4'b0000, 0, 4'h1, 4'h1, 64'h0,  4'hF, 4'hF, 4'hF, 3, 2);
    vec("lu_plus_ret",   1, 4'h1, 4'h9, 4'hF, 4'h3, 4'h3, 64'hEE, 1, 4'h0,  4'b1101, 0, 4'h1, 4'h5, 64'hDD, 4'h3, 4'hF, 4'h4, 3, 2);
    vec("hlt_stat_in",   1, 4'h2, 4'h0, 4'hF, 4'hF, 4'hF, 64'h12, 1, 4'h0,  4'b0000, 1, 4'h0, 4'h0, 64'h0,  4'h0, 4'h0, 4'h0, 4, 3);
    vec("hlt_stat_out",  1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 64'h0,  1, 4'h0,  4'b0000, 0, 4'h2, 4'h0, 64'h12, 4'hF, 4'hF, 4'hF, 4, 3);
    // Repeated mispredicts: bubble_cnt rises from 4 and must hold at 7.
    for (int k = 0; k < 5; k++) begin
      b = (4 + k > 7) ? 7 : 4 + k;
      vec($sformatf("sat_jxx%0d", k), 1, 4'h1, 4'h7, 4'hF, 4'hF, 4'hF, 64'h70 + 64'(k), 1, 4'h0,
          4'b0000, (k != 0), 4'h1, 4'h1, 64'h0, 4'hF, 4'hF, 4'hF, b, 3);
      vec($sformatf("sat_mp%0d", k), 1, 4'h1, 4'h6, 4'hF, 4'h1, 4'h2, 64'h80 + 64'(k), 0, 4'h0,
          4'b0011, 0, 4'h1, 4'h7, 64'h70 + 64'(k), 4'hF, 4'hF, 4'hF, b, 3);
    end
    vec("sat_hold",      1, 4'h1, 4'h7, 4'hF, 4'hF, 4'hF, 64'hA5, 1, 4'h0,  4'b0000, 1, 4'h0, 4'h0, 64'h0,  4'h0, 4'h0, 4'h0, 7, 3);
    vec("rst_mid_mp",    0, 4'h1, 4'h6, 4'hF, 4'h1, 4'h2, 64'h5A, 0, 4'h0,  4'b0011, 0, 4'h1, 4'h7, 64'hA5, 4'hF, 4'hF, 4'hF, 7, 3);
    vec("rst_cleared",   1, 4'h1, 4'h9, 4'hF, 4'h4, 4'h4, 64'h9C, 1, 4'h0,  4'b1010, 1, 4'h0, 4'h0, 64'h0,  4'h0, 4'h0, 4'h0, 0, 0);
    vec("post_rst_ret",  1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 64'h0,  1, 4'h0,  4'b1010, 0, 4'h1, 4'h9, 64'h9C, 4'hF, 4'h4, 4'h4, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end
endmodule
